// File: rtl/aes_job_sequencer.sv
// Multi-block AES job controller: one key expansion per job, then a counted
// fetch -> crypt -> push loop per 128-bit block. Define AES_SEQ_CBC_EN for CBC chaining.
module aes_job_sequencer #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  n_blocks_i,
   input  logic [DATA_W-1:0] iv_i,
   output logic              key_exp_start_o,
   input  logic              key_valid_i,
   input  logic              pt_valid_i,
   output logic              pt_ready_o,
   input  logic [DATA_W-1:0] pt_data_i,
   output logic              core_start_o,
   output logic [DATA_W-1:0] core_data_o,
   input  logic              core_done_i,
   input  logic [DATA_W-1:0] core_data_i,
   output logic              ct_valid_o,
   input  logic              ct_ready_i,
   output logic [DATA_W-1:0] ct_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  blk_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_FETCH, S_CRYPT, S_PUSH, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               first_q;
   logic [CNT_W-1:0]   n_blocks_q, blk_cnt_q;
   logic [DATA_W-1:0]  core_in_q, ct_q;
   logic               last_blk;

   assign last_blk = (CNT_W'(blk_cnt_q + 1'b1) == n_blocks_q);

   // first_q marks the first cycle spent in any state (used by KEY and CRYPT pulses)
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);
      end
   end

   always_comb begin
      state_d         = state_q;
      key_exp_start_o = 1'b0;
      pt_ready_o      = 1'b0;
      core_start_o    = 1'b0;
      ct_valid_o      = 1'b0;
      done_o          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = (n_blocks_i == '0) ? S_DONE : S_KEY;
         end
         S_KEY: begin
            key_exp_start_o = first_q;
            // key_valid_i may still be stale from a previous job in the first cycle
            if (!first_q && key_valid_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            pt_ready_o = 1'b1;
            if (pt_valid_i) state_d = S_CRYPT;
         end
         S_CRYPT: begin
            core_start_o = first_q;
            if (core_done_i) state_d = S_PUSH;
         end
         S_PUSH: begin
            ct_valid_o = 1'b1;
            if (ct_ready_i) state_d = last_blk ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef AES_SEQ_CBC_EN
   logic [DATA_W-1:0] chain_q;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         chain_q <= '0;
      end else if (state_q == S_IDLE && start_i && n_blocks_i != '0) begin
         chain_q <= iv_i;
      end else if (state_q == S_CRYPT && core_done_i) begin
         chain_q <= core_data_i;
      end
   end

   logic [DATA_W-1:0] core_in_d;
   assign core_in_d = pt_data_i ^ chain_q;
`else
   logic [DATA_W-1:0] core_in_d;
   logic              unused_iv;
   assign core_in_d = pt_data_i;
   assign unused_iv = ^iv_i;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         n_blocks_q <= '0;
         blk_cnt_q  <= '0;
         core_in_q  <= '0;
         ct_q       <= '0;
      end else begin
         if (state_q == S_IDLE && start_i) begin
            blk_cnt_q <= '0;
            if (n_blocks_i != '0) n_blocks_q <= n_blocks_i;
         end
         if (state_q == S_FETCH && pt_valid_i) core_in_q <= core_in_d;
         if (state_q == S_CRYPT && core_done_i) ct_q <= core_data_i;
         if (state_q == S_PUSH && ct_ready_i) blk_cnt_q <= blk_cnt_q + 1'b1;
      end
   end

   assign core_data_o = core_in_q;
   assign ct_data_o   = ct_q;
   assign blk_cnt_o   = blk_cnt_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Randomized bench for aes_job_sequencer: a behavioural core/stream environment
// plus per-job expected block lists (ECB, or CBC when AES_SEQ_CBC_EN is defined).
module tb_aes_job_sequencer;
   localparam int DW = 128;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n, clear, start_i, key_valid_i, pt_valid_i;
   logic          core_done_i, ct_ready_i;
   logic [CW-1:0] n_blocks_i;
   logic [DW-1:0] iv_i, pt_data_i, core_data_i;
   logic          key_exp_start_o, pt_ready_o, core_start_o, ct_valid_o, busy_o, done_o;
   logic [DW-1:0] core_data_o, ct_data_o;
   logic [CW-1:0] blk_cnt_o;

   int vec = 0, errs = 0;

   aes_job_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
      .n_blocks_i(n_blocks_i), .iv_i(iv_i), .key_exp_start_o(key_exp_start_o),
      .key_valid_i(key_valid_i), .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o),
      .pt_data_i(pt_data_i), .core_start_o(core_start_o), .core_data_o(core_data_o),
      .core_done_i(core_done_i), .core_data_i(core_data_i), .ct_valid_o(ct_valid_o),
      .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o), .busy_o(busy_o),
      .done_o(done_o), .blk_cnt_o(blk_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // stand-in cipher used by the modelled core
   function automatic logic [DW-1:0] fn(input logic [DW-1:0] x);
      return {x[63:0], x[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
   endfunction

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      start_i = 0; key_valid_i = 0; pt_valid_i = 0; core_done_i = 0;
      ct_ready_i = 0; core_data_i = '0; pt_data_i = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, {key_exp_start_o, pt_ready_o, core_start_o, ct_valid_o, busy_o, done_o}, 0);
      chk({tag, "_cin"}, core_data_o, 0);
      chk({tag, "_ct"}, ct_data_o, 0);
      chk({tag, "_cnt"}, blk_cnt_o, 0);
   endtask

   // mode: 0 complete job, 1 reset_n abort in PUSH, 2 clear abort in PUSH
   task automatic run_job(input int n, input int stall, input int mode);
      logic [DW-1:0] pts[$], exp_in[$], exp_ct[$];
      logic [DW-1:0] chain, cap;
      int pt_idx = 0, ct_idx = 0, kx = 0, cs = 0, lat = 0, vcyc = 0, done_cyc = -1;
      bit pend = 0;
      chain = rnd128();
      iv_i  = chain;
      for (int i = 0; i < n; i++) begin
         pts.push_back(rnd128());
`ifdef AES_SEQ_CBC_EN
         exp_in.push_back(pts[i] ^ chain);
`else
         exp_in.push_back(pts[i]);
`endif
         exp_ct.push_back(fn(exp_in[i]));
         chain = exp_ct[i];
      end
      @(negedge clk);
      start_i = 1; n_blocks_i = CW'(n);
      @(negedge clk);
      start_i = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (key_exp_start_o) kx++;
         if (core_start_o) begin
            chk("core_in", core_data_o, (cs < n) ? exp_in[cs] : '1);
            cap = core_data_o; cs++; pend = 1; lat = $urandom_range(0, 12);
         end
         chk("rdy_excl", {pt_ready_o, ct_valid_o} == 2'b11, 0);
         if (ct_valid_o) begin
            chk("ct_data", ct_data_o, (ct_idx < n) ? exp_ct[ct_idx] : '1);
            vcyc++;
         end else vcyc = 0;
         if (done_o) begin done_cyc = cyc; break; end
         if (mode != 0 && ct_valid_o) begin
            idle_inputs();
            if (mode == 1) reset_n = 0; else clear = 1;
            repeat (2) @(negedge clk);
            chk_all_zero("abort");
            reset_n = 1; clear = 0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("abort_nodone", {done_o, busy_o}, 0);
            end
            return;
         end
         // core model, with spurious done pulses whenever no block is in the core
         if (pend && lat == 0) begin
            core_done_i = 1; core_data_i = fn(cap); pend = 0;
         end else begin
            if (pend) lat--;
            core_done_i = !pend && ($urandom_range(0, 5) == 0);
            core_data_i = rnd128();
         end
         key_valid_i = $urandom_range(0, 1);
         pt_valid_i  = ($urandom_range(0, 3) != 0);
         pt_data_i   = (pt_idx < n) ? pts[pt_idx] : rnd128();
         if (pt_valid_i && pt_ready_o) begin
            chk("pt_extra", pt_idx < n, 1);
            pt_idx++;
         end
         ct_ready_i = (vcyc > stall) && ($urandom_range(0, 3) != 0);
         if (ct_valid_o && ct_ready_i) ct_idx++;
         start_i    = busy_o && ($urandom_range(0, 7) == 0);
         n_blocks_i = CW'($urandom);
      end
      idle_inputs();
      chk("timeout", done_cyc >= 0, 1);
      if (n == 0) chk("zero_lat", done_cyc, 0);
      chk("done_cnt", blk_cnt_o, n);
      chk("ct_pushed", ct_idx, n);
      chk("key_pulses", kx, (n != 0) ? 1 : 0);
      chk("core_pulses", cs, n);
      @(negedge clk);
      chk("post_done", {done_o, busy_o}, 0);
      chk("cnt_hold", blk_cnt_o, n);
   endtask

   initial begin
      reset_n = 0; clear = 0; n_blocks_i = '0; iv_i = '0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1;
      @(negedge clk);
      run_job(0, 0, 0);
      run_job(3, 0, 0);
      run_job(2, 20, 0);
      run_job(1, 0, 0);
      run_job(15, 0, 0);
      run_job(2, 0, 1);
      run_job(3, 0, 2);
      run_job(2, 0, 0);
      for (int j = 0; j < 12; j++) run_job($urandom_range(0, 6), $urandom_range(0, 4), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
